// File: rtl/packet_transmitter.sv
// rtl/packet_transmitter.sv - output-port serializer streaming one buffered packet per start
// Reads SRC, DST, SIZE, DATA..., CRC by address and frees the slot with a one-cycle rinc pulse.
module packet_transmitter #(
    parameter int UWIDTH = 8,
    parameter int PTR_SZ = 4,
    parameter int GAP    = 1
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              rempty,
    input  logic [UWIDTH-1:0] rdata,
    input  logic              stop_packet_send_i,
    output logic [PTR_SZ-1:0] raddr,
    output logic              rinc,
    output logic              packet_valid_o,
    output logic [UWIDTH-1:0] pdata_o,
    output logic              busy_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [2:0]        GAP_INIT  = 3'(GAP - 1);
    localparam logic [PTR_SZ-1:0] IDX_SIZE  = PTR_SZ'(2);
    localparam logic [PTR_SZ-1:0] IDX_FIRST = PTR_SZ'(3);

    logic [1:0]        state_q, state_d;
    logic [PTR_SZ-1:0] idx_q, idx_d;
    logic [2:0]        n_q, n_d;
    logic [2:0]        gap_cnt_q, gap_cnt_d;
    logic              rinc_q, rinc_d;
    logic              valid_q, valid_d;
    logic [UWIDTH-1:0] pdata_q, pdata_d;
    logic [PTR_SZ-1:0] last_idx;
    logic              at_last;

    // SIZE low bits of zero encode eight data bytes; CRC sits at N+3.
    assign last_idx = (n_q == 3'd0) ? PTR_SZ'(11) : (PTR_SZ'(n_q) + PTR_SZ'(3));
    assign at_last  = (idx_q >= IDX_FIRST) && (idx_q == last_idx);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        n_d       = n_q;
        gap_cnt_d = gap_cnt_q;
        rinc_d    = 1'b0;
        valid_d   = 1'b0;
        pdata_d   = pdata_q;
        case (state_q)
            S_IDLE: begin
                if (!rempty && !stop_packet_send_i) begin
                    idx_d   = '0;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                pdata_d = rdata;
                valid_d = 1'b1;
                if (idx_q == IDX_SIZE) begin
                    n_d = rdata[2:0];
                end
                if (at_last) begin
                    rinc_d    = 1'b1;
                    state_d   = S_GAP;
                    gap_cnt_d = GAP_INIT;
                    idx_d     = '0;
                end else begin
                    idx_d = idx_q + PTR_SZ'(1);
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 3'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            n_q       <= 3'd0;
            gap_cnt_q <= 3'd0;
            rinc_q    <= 1'b0;
            valid_q   <= 1'b0;
            pdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            n_q       <= n_d;
            gap_cnt_q <= gap_cnt_d;
            rinc_q    <= rinc_d;
            valid_q   <= valid_d;
            pdata_q   <= pdata_d;
        end
    end

    assign raddr          = idx_q;
    assign rinc           = rinc_q;
    assign packet_valid_o = valid_q;
    assign pdata_o        = pdata_q;
    assign busy_o         = (state_q != S_IDLE);

endmodule
